ov7670_stim_gen: RTL

- Synthesizable OV7670 sensor stand-in. It generates the PCLK, VSYNC, HREF and D[7:0] timing and pixel bytes that the camera capture path expects.
- Used in bench frames and in on-board loopback, in place of the real camera pins.
- Parametrised successor to the fixed-stimulus frame: frame geometry, bytes/pixel, blanking and PCLK ratio are all generic.
- Adds selectable test patterns, a frame count and a graceful stop.

---
 rtl/ov7670_stim_pkg.sv | 40 ++++
 rtl/ov7670_pclk_gen.sv | 39 +++
 rtl/ov7670_stim_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ov7670_stim_pkg.sv
// Shared types and constants for the OV7670 sensor stand-in.
// Covers frame-segment states, test-pattern codes, the colour-bar table and width helpers.
package ov7670_stim_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      VBACK  = 3'd2,
      ACTIVE = 3'd3,
      VFRONT = 3'd4
   } stim_state_e;

   typedef enum logic [1:0] {
      PAT_RAMP  = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_CONST = 2'd2,
      PAT_CHECK = 2'd3
   } pattern_e;

   // RGB565 colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [15:0] BAR_RGB565 [8] = '{
      16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
      16'hF81F, 16'hF800, 16'h001F, 16'h0000
   };

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/ov7670_pclk_gen.sv
// PCLK divider for the sensor stand-in: holds PCLK low while disabled, starts low-first,
// and raises a one-clk tick on the clk edge where PCLK falls.
module ov7670_pclk_gen
   import ov7670_stim_pkg::*;
#(
   parameter int unsigned PCLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_,
   input  logic en,
   output logic pclk,
   output logic tick
);

   localparam int unsigned HALF = PCLK_DIV / 2;
   localparam int unsigned CW   = cnt_width(HALF);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == CW'(HALF - 1));
   assign tick = en & pclk & wrap;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cnt  <= '0;
         pclk <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         pclk <= 1'b0;
      end else if (wrap) begin
         cnt  <= '0;
         pclk <= ~pclk;
      end else begin
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ov7670_stim_gen.sv
// OV7670 sensor stand-in: drives PCLK/VSYNC/HREF/D with configurable geometry and test patterns.
// Pin outputs are registered from the next raster position so they only move on PCLK falling edges.
module ov7670_stim_gen
   import ov7670_stim_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned BPP         = 2,
   parameter int unsigned H_BLANK     = 144,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned V_BACK      = 17,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned PCLK_DIV    = 2
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        start,
   input  logic        stop,
   input  logic [1:0]  pattern_sel,
   input  logic [7:0]  const_byte,
   input  logic [15:0] num_frames,
   output logic        PCLK_PIN,
   output logic        VSYNC_PIN,
   output logic        HREF_PIN,
   output logic [7:0]  D_PIN,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_cnt,
   output logic [2:0]  dbg_state
);

   // start and stop are single-cycle request pulses with no ready: start is honoured only in
   // IDLE (and then wins over a coincident stop); stop is honoured only while busy.

   localparam int unsigned HB      = H_ACTIVE * BPP;
   localparam int unsigned LP      = HB + H_BLANK;
   localparam int unsigned HW      = cnt_width(LP);
   localparam int unsigned LW      = cnt_width(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT));
   localparam int unsigned BAR_PIX = H_ACTIVE / 8;

   stim_state_e   state, nxt_state;
   logic [HW-1:0] hcnt, nxt_hcnt, pix;
   logic [LW-1:0] lcnt, nxt_lcnt, seg_last;
   logic          tick, pclk, frame_end, stop_pend, last_frame, href_n;
   logic [15:0]   frames_q, rgb;
   logic [7:0]    const_q, d_n;
   logic [2:0]    bar;
   pattern_e      pat_q;

   ov7670_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk (
      .clk    (clk),
      .reset_ (reset_),
      .en     (state != IDLE),
      .pclk   (pclk),
      .tick   (tick)
   );

   always_comb begin
      case (state)
         VSYNC:   seg_last = LW'(VSYNC_LINES - 1);
         VBACK:   seg_last = LW'(V_BACK - 1);
         ACTIVE:  seg_last = LW'(V_ACTIVE - 1);
         VFRONT:  seg_last = LW'(V_FRONT - 1);
         default: seg_last = '0;
      endcase
   end

   assign last_frame = (frames_q != 16'd0) && ((frame_cnt + 16'd1) == frames_q);

   always_comb begin
      nxt_state = state;
      nxt_hcnt  = hcnt;
      nxt_lcnt  = lcnt;
      frame_end = 1'b0;
      if (state == IDLE) begin
         if (start) begin
            nxt_state = VSYNC;
            nxt_hcnt  = '0;
            nxt_lcnt  = '0;
         end
      end else if (tick) begin
         if (hcnt == HW'(LP - 1)) begin
            nxt_hcnt = '0;
            if (lcnt == seg_last) begin
               nxt_lcnt = '0;
               case (state)
                  VSYNC:  nxt_state = VBACK;
                  VBACK:  nxt_state = ACTIVE;
                  ACTIVE: nxt_state = VFRONT;
                  VFRONT: begin
                     frame_end = 1'b1;
                     // a stop arriving on the very last tick still ends the sequence here
                     nxt_state = (last_frame || stop_pend || stop) ? IDLE : VSYNC;
                  end
                  default: nxt_state = IDLE;
               endcase
            end else begin
               nxt_lcnt = lcnt + 1'b1;
            end
         end else begin
            nxt_hcnt = hcnt + 1'b1;
         end
      end
   end

   always_comb begin
      pix    = (BPP == 2) ? (nxt_hcnt >> 1) : nxt_hcnt;
      bar    = 3'(pix / HW'(BAR_PIX));
      rgb    = BAR_RGB565[bar];
      href_n = (nxt_state == ACTIVE) && (nxt_hcnt < HW'(HB));
      d_n    = 8'h00;
      if (href_n) begin
         case (pat_q)
            PAT_RAMP:  d_n = 8'(nxt_hcnt) + 8'(nxt_lcnt);
            PAT_BARS:  d_n = ((BPP == 2) && nxt_hcnt[0]) ? rgb[7:0] : rgb[15:8];
            PAT_CONST: d_n = const_q;
            default:   d_n = (pix[0] ^ nxt_lcnt[0]) ? 8'h00 : 8'hFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state      <= IDLE;
         hcnt       <= '0;
         lcnt       <= '0;
         VSYNC_PIN  <= 1'b0;
         HREF_PIN   <= 1'b0;
         D_PIN      <= 8'h00;
         frame_done <= 1'b0;
         frame_cnt  <= 16'd0;
         frames_q   <= 16'd0;
         pat_q      <= PAT_RAMP;
         const_q    <= 8'h00;
         stop_pend  <= 1'b0;
      end else begin
         state      <= nxt_state;
         hcnt       <= nxt_hcnt;
         lcnt       <= nxt_lcnt;
         VSYNC_PIN  <= (nxt_state == VSYNC);
         HREF_PIN   <= href_n;
         D_PIN      <= d_n;
         frame_done <= frame_end;
         if ((state == IDLE) && start) begin
            frame_cnt <= 16'd0;
            frames_q  <= num_frames;
            pat_q     <= pattern_e'(pattern_sel);
            const_q   <= const_byte;
         end else if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (nxt_state == IDLE)
            stop_pend <= 1'b0;
         else if ((state != IDLE) && stop)
            stop_pend <= 1'b1;
      end
   end

   assign busy      = (state != IDLE);
   assign PCLK_PIN  = pclk;
   assign dbg_state = state;

endmodule
